cache_write_buffer: RTL and testbench
=====================================

# cache_write_buffer

Line-granular store buffer that sits directly downstream of the store-path line/strobe generator in the D-cache. It accepts 128-bit line data with 16-bit byte strobes, holds up to DEPTH pending line writes, and optionally merges back-to-back stores to the same line. It drains entries in order to the memory-side write port over a valid/ready handshake. It also offers a combinational lookup port so loads can forward pending store bytes.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_W, 28, line address width, i.e. byte address bits [31:4].
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  store request valid
- wr_ready  out  1  buffer can accept; equals !full and depends on registered state only
- wr_line_addr  in  ADDR_W  line address of the store
- wr_data  in  128  line data; only strobed bytes are meaningful
- wr_strb  in  16  byte enables; bit i covers data[8i+7:8i]
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts head
- mem_line_addr  out  ADDR_W  head line address
- mem_data  out  128  head data
- mem_strb  out  16  head byte enables
- lookup_addr  in  ADDR_W  load line address to search
- lookup_hit  out  1  some valid entry matches lookup_addr
- lookup_data  out  128  data of the youngest matching entry
- lookup_strb  out  16  strobes of the youngest matching entry; 0 when there is no hit
- empty  out  1  no valid entries
- full  out  1  count == DEPTH

## Operation
- Circular FIFO with head pointer, tail pointer and count of $clog2(DEPTH)+1 bits. Each entry holds {addr, data, strb}.
- Push: when wr_valid && wr_ready and no merge applies, write {wr_line_addr, wr_data & byte-mask(wr_strb), wr_strb} at tail, tail++ (wraps at DEPTH), count++.
- Merge (WBUF_MERGE_EN only):
  - Condition: wr_valid && wr_ready && count>=2 && wr_line_addr == addr of the youngest entry (tail-1).
  - Action: bytes with wr_strb=1 overwrite data; strb |= wr_strb. Count and tail are unchanged.
  - The head entry is never a merge target, because it is already exposed on the mem port.
- Pop: on mem_valid && mem_ready, head++ (wraps at DEPTH), count--, and the entry is invalidated.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Simultaneous merge and pop: only the pop changes count.
  - When count==2, the youngest entry becomes head on the next cycle.
  - The merge data is still written before that entry becomes head.
- Full: wr_ready=0 even when a pop occurs in the same cycle; a push is accepted on the following cycle.
- Empty: mem_valid=0; mem_* outputs hold their last values and must be ignored.
- Lookup:
  - Purely combinational over valid entries.
  - lookup_hit is the OR over entries of (valid && addr == lookup_addr).
  - lookup_data and lookup_strb come from the matching entry that is youngest in FIFO age order.
  - The consumer stalls a load if lookup_strb does not cover its bytes.
  - Lookup does not see a store being accepted in the same cycle.

## Timing
- Reset values: all entries invalid, pointers 0, count 0, so empty=1, full=0, wr_ready=1, mem_valid=0, lookup_hit=0, lookup_strb=0; mem_data, mem_strb and mem_line_addr are 0.
- Push-to-mem_valid latency: 1 cycle. An entry accepted at edge N is on the mem port after edge N if the buffer was empty.
- mem_valid = !empty, taken from registered state. Once mem_valid rises, mem_line_addr, mem_data and mem_strb stay stable until the handshake completes.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: all pending entries are discarded immediately and asynchronously; the memory side must tolerate a dropped mem_valid.

## Configuration
- WBUF_MERGE_EN defined: merge into the youngest non-head entry as above.
- WBUF_MERGE_EN undefined: every accepted store allocates a new entry; the merge comparator is not built.

## Structure
- WORD, CACHE_LINE_BIT_LENGTH (128) and CACHE_LINE_SIZE (16) come from the shared cache define file Cache_define_macro.v.
- The line-address width macro and the default DEPTH are added to that same file.
- One sub-module, wbuf_byte_merge: combinational merge of {old_data, old_strb} with {new_data, new_strb}. It is used for the merge write and for the strobe-mask on push.

## Test plan
- Reset: rst_n low then released -> empty=1, wr_ready=1, mem_valid=0, mem_strb=0.
- Single store: addr 0x0000001, wr_strb 0x00F0, data word 1 = 0xDEADBEEF, mem_ready=0 -> next cycle mem_valid=1, mem_strb=0x00F0; outputs stable over 5 stalled cycles; pop on mem_ready=1 -> empty=1.
- Merge (macro on): head holds addr 0x10. Store addr 0x20 strb 0x000F, then addr 0x20 strb 0x0F03 with new byte0 -> count=2, entry strb 0x0F0F, byte0 equals the newer value. With the macro off, the same stimulus gives count=3.
- Full/simultaneous: 4 stores with mem_ready=0 -> full=1, wr_ready=0. Then wr_valid=1 and mem_ready=1 in the same cycle -> pop only, count=3; next cycle wr_ready=1.
- Lookup: entries for addr 0x30 strb 0x0001, then 0x40, then 0x30 strb 0x0010 -> lookup_addr 0x30 gives hit=1, strb=0x0010; lookup_addr 0x50 gives hit=0, strb=0.
- Reset mid-drain: 3 entries pending, mem_valid=1, rst_n pulsed low -> mem_valid=0 and empty=1 asynchronously; no stale entry drains after release.

Source files
------------

// File: rtl/cache_write_buffer_pkg.sv
// Shared cache constants and payload types for the D-cache store buffer.
// Line geometry, line-address width and default buffer depth live here so the
// store path, the buffer and its bench agree on them.
package cache_write_buffer_pkg;

    localparam int unsigned CACHE_LINE_BIT_LENGTH = 128;
    localparam int unsigned CACHE_LINE_SIZE       = CACHE_LINE_BIT_LENGTH / 8;
    localparam int unsigned LINE_ADDR_W           = 28;
    localparam int unsigned WBUF_DEPTH            = 4;

    // Line payload: data plus per-byte enables.
    typedef struct packed {
        logic [CACHE_LINE_BIT_LENGTH-1:0] data;
        logic [CACHE_LINE_SIZE-1:0]       strb;
    } wbuf_line_t;

endpackage

// File: rtl/wbuf_byte_merge.sv
// Combinational byte merge: strobed bytes of i_new overwrite i_old, strobes OR.
// With i_old = 0 it reduces to masking i_new.data by i_new.strb.
// Ports: i_old (existing line), i_new (incoming line), o_merged (result).
module wbuf_byte_merge
    import cache_write_buffer_pkg::*;
(
    input  wbuf_line_t i_old,
    input  wbuf_line_t i_new,
    output wbuf_line_t o_merged
);

    always_comb begin
        o_merged      = i_old;
        o_merged.strb = i_old.strb | i_new.strb;
        for (int b = 0; b < int'(CACHE_LINE_SIZE); b++) begin
            if (i_new.strb[b]) begin
                o_merged.data[8*b +: 8] = i_new.data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/cache_write_buffer.sv
// Line-granular in-order store buffer with load-forwarding lookup.
// Optional merge of a store into the youngest non-head entry: WBUF_MERGE_EN.
// Ports: clk/rst_n; wr_* store input (valid/ready); mem_* head output
// (valid/ready); lookup_addr -> lookup_hit/data/strb (combinational);
// empty/full status.
module cache_write_buffer
    import cache_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = LINE_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ADDR_W-1:0]                wr_line_addr,
    input  logic [CACHE_LINE_BIT_LENGTH-1:0] wr_data,
    input  logic [CACHE_LINE_SIZE-1:0]       wr_strb,
    output logic                             mem_valid,
    input  logic                             mem_ready,
    output logic [ADDR_W-1:0]                mem_line_addr,
    output logic [CACHE_LINE_BIT_LENGTH-1:0] mem_data,
    output logic [CACHE_LINE_SIZE-1:0]       mem_strb,
    input  logic [ADDR_W-1:0]                lookup_addr,
    output logic                             lookup_hit,
    output logic [CACHE_LINE_BIT_LENGTH-1:0] lookup_data,
    output logic [CACHE_LINE_SIZE-1:0]       lookup_strb,
    output logic                             empty,
    output logic                             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr  [DEPTH];
    wbuf_line_t        r_line  [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    // Last popped head; keeps mem_* steady while the buffer is empty.
    logic [ADDR_W-1:0] r_last_addr;
    wbuf_line_t        r_last_line;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_merge;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_idx;
    wbuf_line_t        w_old_line;
    wbuf_line_t        w_in_line;
    wbuf_line_t        w_new_line;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == CNT_W'(0));
    assign w_accept = wr_valid && !w_full;
    assign w_pop    = !w_empty && mem_ready;

`ifdef WBUF_MERGE_EN
    logic [PTR_W-1:0] w_youngest;
    assign w_youngest = r_tail - PTR_W'(1);
    // count>=2 keeps the head (already on the mem port) out of reach.
    assign w_merge    = w_accept && (r_count >= CNT_W'(2)) &&
                        (wr_line_addr == r_addr[w_youngest]);
    assign w_wr_idx   = w_merge ? w_youngest : r_tail;
    assign w_old_line = w_merge ? r_line[w_youngest] : '0;
`else
    assign w_merge    = 1'b0;
    assign w_wr_idx   = r_tail;
    assign w_old_line = '0;
`endif

    assign w_push         = w_accept && !w_merge;
    assign w_in_line.data = wr_data;
    assign w_in_line.strb = wr_strb;

    wbuf_byte_merge u_merge (
        .i_old    (w_old_line),
        .i_new    (w_in_line),
        .o_merged (w_new_line)
    );

    // FIFO storage, pointers and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_addr[i] <= '0;
                r_line[i] <= '0;
            end
            r_valid     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_last_addr <= '0;
            r_last_line <= '0;
        end else begin
            if (w_accept) begin
                r_addr[w_wr_idx]  <= wr_line_addr;
                r_line[w_wr_idx]  <= w_new_line;
                r_valid[w_wr_idx] <= 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
                r_last_addr     <= r_addr[r_head];
                r_last_line     <= r_line[r_head];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign empty         = w_empty;
    assign full          = w_full;
    assign wr_ready      = !w_full;
    assign mem_valid     = !w_empty;
    assign mem_line_addr = w_empty ? r_last_addr      : r_addr[r_head];
    assign mem_data      = w_empty ? r_last_line.data : r_line[r_head].data;
    assign mem_strb      = w_empty ? r_last_line.strb : r_line[r_head].strb;

    // Walk oldest to youngest so the youngest match wins.
    logic [PTR_W-1:0] w_lk_idx;
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lookup_strb = '0;
        w_lk_idx    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_lk_idx = r_head + PTR_W'(i);
            if (r_valid[w_lk_idx] && (r_addr[w_lk_idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_line[w_lk_idx].data;
                lookup_strb = r_line[w_lk_idx].strb;
            end
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed self-checking bench for cache_write_buffer.
module tb_cache_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [27:0]  wr_line_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_strb;
    logic         mem_valid;
    logic         mem_ready;
    logic [27:0]  mem_line_addr;
    logic [127:0] mem_data;
    logic [15:0]  mem_strb;
    logic [27:0]  lookup_addr;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic [15:0]  lookup_strb;
    logic         empty;
    logic         full;

    int checks = 0;
    int errors = 0;

    cache_write_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_line_addr  (wr_line_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_line_addr (mem_line_addr),
        .mem_data      (mem_data),
        .mem_strb      (mem_strb),
        .lookup_addr   (lookup_addr),
        .lookup_hit    (lookup_hit),
        .lookup_data   (lookup_data),
        .lookup_strb   (lookup_strb),
        .empty         (empty),
        .full          (full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [27:0] a, input logic [127:0] d, input logic [15:0] s);
        wr_valid     = 1'b1;
        wr_line_addr = a;
        wr_data      = d;
        wr_strb      = s;
        tick();
        wr_valid     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b exp 1", wr_ready); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b exp 0", mem_valid); end
        checks++; if (mem_strb !== 16'h0) begin errors++; $display("FAIL reset_mem_strb: got %h exp 0", mem_strb); end
        checks++; if (mem_data !== 128'h0) begin errors++; $display("FAIL reset_mem_data: got %h exp 0", mem_data); end
        checks++; if (lookup_hit !== 1'b0 || lookup_strb !== 16'h0) begin errors++; $display("FAIL reset_lookup: got hit %b strb %h exp 0/0", lookup_hit, lookup_strb); end
    endtask

    task automatic test_single_store();
        logic [127:0] exp_d;
        exp_d = {64'h0, 32'hDEADBEEF, 32'h0};
        mem_ready = 1'b0;
        store(28'h0000001, {32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h33333333}, 16'h00F0);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", mem_valid); end
        checks++; if (mem_strb !== 16'h00F0) begin errors++; $display("FAIL single_strb: got %h exp 00f0", mem_strb); end
        checks++; if (mem_data !== exp_d) begin errors++; $display("FAIL single_data: got %h exp %h", mem_data, exp_d); end
        checks++; if (mem_line_addr !== 28'h1) begin errors++; $display("FAIL single_addr: got %h exp 1", mem_line_addr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (mem_valid !== 1'b1 || mem_strb !== 16'h00F0 || mem_data !== exp_d || mem_line_addr !== 28'h1) begin
                errors++;
                $display("FAIL single_stall%0d: got v %b a %h s %h d %h", i, mem_valid, mem_line_addr, mem_strb, mem_data);
            end
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got empty %b valid %b exp 1/0", empty, mem_valid); end
        checks++; if (mem_strb !== 16'h00F0) begin errors++; $display("FAIL single_hold: got %h exp 00f0", mem_strb); end
    endtask

    task automatic test_merge();
        logic [127:0] exp_d;
        logic [15:0]  exp_s;
        int           exp_n;
        int           n;
`ifdef WBUF_MERGE_EN
        exp_d = 128'h00000000_C3C2C1C0_00000000_4433BBAA;
        exp_s = 16'h0F0F;
        exp_n = 2;
`else
        exp_d = 128'h00000000_C3C2C1C0_00000000_0000BBAA;
        exp_s = 16'h0F03;
        exp_n = 3;
`endif
        mem_ready = 1'b0;
        store(28'h10, {4{32'h12345678}}, 16'hFFFF);
        store(28'h20, 128'h0000_0000_0000_0000_0000_0000_4433_2211, 16'h000F);
        store(28'h20, 128'hFFFFFFFF_C3C2C1C0_000000EE_9999BBAA, 16'h0F03);
        lookup_addr = 28'h20;
        #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_strb !== exp_s) begin errors++; $display("FAIL merge_strb: got hit %b strb %h exp 1/%h", lookup_hit, lookup_strb, exp_s); end
        checks++; if (lookup_data !== exp_d) begin errors++; $display("FAIL merge_data: got %h exp %h", lookup_data, exp_d); end
        checks++; if (mem_line_addr !== 28'h10) begin errors++; $display("FAIL merge_head: got %h exp 10", mem_line_addr); end
        n = 0;
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (mem_valid === 1'b1) n++;
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (n !== exp_n) begin errors++; $display("FAIL merge_count: got %0d entries exp %0d", n, exp_n); end
    endtask

    task automatic test_full_simul();
        logic [27:0] exp_a [3];
        int          n;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(28'h100 + 28'(i), 128'(i + 1), 16'hFFFF);
        checks++; if (full !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_flag: got full %b ready %b exp 1/0", full, wr_ready); end
        wr_valid     = 1'b1;
        wr_line_addr = 28'h200;
        wr_data      = 128'h5;
        wr_strb      = 16'hFFFF;
        mem_ready    = 1'b1;
        tick();
        wr_valid  = 1'b0;
        mem_ready = 1'b0;
        checks++; if (full !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL full_pop_only: got full %b ready %b exp 0/1", full, wr_ready); end
        checks++; if (mem_line_addr !== 28'h101) begin errors++; $display("FAIL full_head: got %h exp 101", mem_line_addr); end
        lookup_addr = 28'h200;
        #1;
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL full_dropped: got hit %b exp 0", lookup_hit); end
        // push and pop together at count 3: count stays 3
        wr_valid     = 1'b1;
        wr_line_addr = 28'h104;
        mem_ready    = 1'b1;
        tick();
        wr_valid  = 1'b0;
        exp_a[0] = 28'h102; exp_a[1] = 28'h103; exp_a[2] = 28'h104;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_valid === 1'b1) begin
                if (n < 3) begin
                    checks++;
                    if (mem_line_addr !== exp_a[n]) begin errors++; $display("FAIL drain_addr%0d: got %h exp %h", n, mem_line_addr, exp_a[n]); end
                end
                n++;
            end
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("FAIL drain_count: got %0d exp 3", n); end
    endtask

    task automatic test_lookup();
        mem_ready = 1'b0;
        store(28'h30, 128'h5A, 16'h0001);
        store(28'h40, {4{32'hCAFEF00D}}, 16'hFFFF);
        store(28'h30, 128'h77_0000_0000, 16'h0010);
        lookup_addr = 28'h30;
        #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_strb !== 16'h0010) begin errors++; $display("FAIL lookup_young: got hit %b strb %h exp 1/0010", lookup_hit, lookup_strb); end
        checks++; if (lookup_data !== 128'h77_0000_0000) begin errors++; $display("FAIL lookup_data: got %h exp 7700000000", lookup_data); end
        lookup_addr = 28'h40;
        #1;
        checks++; if (lookup_hit !== 1'b1 || lookup_strb !== 16'hFFFF) begin errors++; $display("FAIL lookup_40: got hit %b strb %h exp 1/ffff", lookup_hit, lookup_strb); end
        lookup_addr = 28'h50;
        #1;
        checks++; if (lookup_hit !== 1'b0 || lookup_strb !== 16'h0) begin errors++; $display("FAIL lookup_miss: got hit %b strb %h exp 0/0", lookup_hit, lookup_strb); end
    endtask

    task automatic test_reset_mid();
        int n;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b exp 1", mem_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_async: got valid %b empty %b exp 0/1", mem_valid, empty); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        mem_ready   = 1'b1;
        lookup_addr = 28'h30;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (mem_valid !== 1'b0 || lookup_hit !== 1'b0) n++;
        end
        mem_ready = 1'b0;
        checks++; if (n !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale cycles exp 0", n); end
    endtask

    initial begin
        rst_n        = 1'b0;
        wr_valid     = 1'b0;
        wr_line_addr = '0;
        wr_data      = '0;
        wr_strb      = '0;
        mem_ready    = 1'b0;
        lookup_addr  = '0;
        test_reset();
        test_single_store();
        test_merge();
        test_full_simul();
        test_lookup();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
